seq_detector_param: RTL and testbench

Parametrised serial bit-pattern detector with selectable overlap mode, a combinational Mealy match output, a registered Moore-style match output, and a saturating match counter. It is the next-generation replacement for the fixed-pattern Mealy detector. It sits on a single-bit serial input stream, qualified by a valid strobe, and flags the last bit of each occurrence of `PATTERN`.

---
 rtl/seq_detector_param_pkg.sv | 24 ++
 rtl/sat_counter.sv | 37 +++
 rtl/seq_detector_param.sv | 71 +++++++
 tb/tb_seq_detector_param.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detector_param_pkg.sv
// Shared helpers for the serial pattern detector and its match counter.
// Pure elaboration-time functions; no logic, no latency, no flow control.
package seq_detector_param_pkg;

  // Ceiling log2, minimum 1, used to size the history fill counter.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    if (result < 1) result = 1;
    return result;
  endfunction

  // Largest value an unsigned counter of the given width can hold.
  function automatic longint unsigned cnt_max(input int width);
    return (longint'(1) << width) - 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
// Updates one cycle after inc/clr; no backpressure, holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial PATTERN detector: combinational Mealy out, registered out_q, saturating count.
// out is zero-latency; out_q/match_cnt follow one cycle later; valid=0 freezes state.
module seq_detector_param
  import seq_detector_param_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data,
  input  logic             valid,
  input  logic             cnt_clr,
  output logic             out,
  output logic             out_q,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int               FILL_W    = clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

  logic [PAT_W-2:0]  hist_q;
  logic [PAT_W-2:0]  hist_d;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_d;
  logic [PAT_W-1:0]  window;

  // Oldest history bit lands in the MSB, matching PATTERN's first-received bit.
  assign window = {hist_q, data};

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    out    = valid && (fill_q == FILL_FULL) && (window == PATTERN);
    if (valid) begin
      hist_d = window[PAT_W-2:0];
      if (fill_q != FILL_FULL) begin
        fill_d = fill_q + 1'b1;
      end
      // Emptying the fill count is enough to stop matched bits being reused.
      if (out && !OVERLAP) begin
        fill_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= out;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (out),
    .q   (match_cnt)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: three detector instances (overlap, non-overlap, 2-bit counter)
// share one stimulus stream and are checked against a bit-list reference model.
module tb_seq_detector_param;

  localparam int         PAT_W = 4;
  localparam logic [3:0] PAT   = 4'b1001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data = 1'b0;
  logic valid = 1'b0;
  logic cnt_clr = 1'b0;

  logic       out_ov, out_no, out_sat;
  logic       outq_ov, outq_no, outq_sat;
  logic [7:0] cnt_ov_o, cnt_no_o;
  logic [1:0] cnt_sat_o;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(PAT_W), .PATTERN(PAT), .OVERLAP(1'b1), .CNT_W(8)) dut_ov (
    .clk(clk), .rst(rst), .data(data), .valid(valid), .cnt_clr(cnt_clr),
    .out(out_ov), .out_q(outq_ov), .match_cnt(cnt_ov_o));

  seq_detector_param #(.PAT_W(PAT_W), .PATTERN(PAT), .OVERLAP(1'b0), .CNT_W(8)) dut_no (
    .clk(clk), .rst(rst), .data(data), .valid(valid), .cnt_clr(cnt_clr),
    .out(out_no), .out_q(outq_no), .match_cnt(cnt_no_o));

  seq_detector_param #(.PAT_W(PAT_W), .PATTERN(PAT), .OVERLAP(1'b1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .data(data), .valid(valid), .cnt_clr(cnt_clr),
    .out(out_sat), .out_q(outq_sat), .match_cnt(cnt_sat_o));

  typedef struct {
    bit o_ov;
    bit o_no;
    bit q_ov;
    bit q_no;
    int c_ov;
    int c_no;
    int c_sat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: accepted bits since the last restart, plus plain integer counters.
  bit win_ov[$];
  bit win_no[$];
  int m_cnt_ov, m_cnt_no, m_cnt_sat;
  bit m_q_ov, m_q_no;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit hit(input bit w[$], input bit d);
    int base;
    if (w.size() < PAT_W - 1) return 1'b0;
    base = w.size() - (PAT_W - 1);
    for (int k = 0; k < PAT_W - 1; k++) begin
      if (w[base + k] != PAT[PAT_W - 1 - k]) return 1'b0;
    end
    return d == PAT[0];
  endfunction

  function automatic int sat_inc(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  task automatic model_reset();
    win_ov.delete();
    win_no.delete();
    m_cnt_ov  = 0;
    m_cnt_no  = 0;
    m_cnt_sat = 0;
    m_q_ov    = 1'b0;
    m_q_no    = 1'b0;
  endtask

  task automatic step(input bit d, input bit v, input bit c);
    exp_t e;
    bit   h_ov, h_no;
    @(posedge clk);
    #1;
    data    = d;
    valid   = v;
    cnt_clr = c;
    h_ov = v && hit(win_ov, d);
    h_no = v && hit(win_no, d);
    e.o_ov  = h_ov;
    e.o_no  = h_no;
    e.q_ov  = m_q_ov;
    e.q_no  = m_q_no;
    e.c_ov  = m_cnt_ov;
    e.c_no  = m_cnt_no;
    e.c_sat = m_cnt_sat;
    sb.push_back(e);
    if (v) begin
      win_ov.push_back(d);
      win_no.push_back(d);
      if (win_ov.size() > PAT_W) void'(win_ov.pop_front());
      if (h_no) win_no.delete();
      else if (win_no.size() > PAT_W) void'(win_no.pop_front());
    end
    m_q_ov = h_ov;
    m_q_no = h_no;
    if (c) begin
      m_cnt_ov  = 0;
      m_cnt_no  = 0;
      m_cnt_sat = 0;
    end else begin
      if (h_ov) m_cnt_ov  = sat_inc(m_cnt_ov, 255);
      if (h_no) m_cnt_no  = sat_inc(m_cnt_no, 255);
      if (h_ov) m_cnt_sat = sat_inc(m_cnt_sat, 3);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    check({tag, "_out_ov"}, int'(out_ov), 0);
    check({tag, "_out_no"}, int'(out_no), 0);
    check({tag, "_outq_ov"}, int'(outq_ov), 0);
    check({tag, "_outq_sat"}, int'(outq_sat), 0);
    check({tag, "_cnt_ov"}, int'(cnt_ov_o), 0);
    check({tag, "_cnt_no"}, int'(cnt_no_o), 0);
    check({tag, "_cnt_sat"}, int'(cnt_sat_o), 0);
  endtask

  // Reset lands mid-cycle, and outputs must clear before any clock edge.
  task automatic async_reset();
    @(posedge clk);
    #1;
    valid   = 1'b0;
    cnt_clr = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send(input bit bits[$], input bit v);
    foreach (bits[i]) step(bits[i], v, 1'b0);
  endtask

  exp_t me;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      check("out_ov", int'(out_ov), int'(me.o_ov));
      check("out_no", int'(out_no), int'(me.o_no));
      check("out_sat", int'(out_sat), int'(me.o_ov));
      check("outq_ov", int'(outq_ov), int'(me.q_ov));
      check("outq_no", int'(outq_no), int'(me.q_no));
      check("outq_sat", int'(outq_sat), int'(me.q_ov));
      check("cnt_ov", int'(cnt_ov_o), me.c_ov);
      check("cnt_no", int'(cnt_no_o), me.c_no);
      check("cnt_sat", int'(cnt_sat_o), me.c_sat);
    end
  end

  initial begin
    model_reset();
    #2;
    chk_all_zero("por");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Overlap vs non-overlap on 1001001.
    send('{1, 0, 0, 1, 0, 0, 1}, 1'b1);
    step(0, 0, 0);
    @(negedge clk);
    #1;
    check("dir_overlap_cnt", int'(cnt_ov_o), 2);
    check("dir_nonoverlap_cnt", int'(cnt_no_o), 1);

    // Pattern straddling a valid gap with data toggling.
    async_reset();
    send('{1, 0}, 1'b1);
    send('{1, 0, 1, 0, 1}, 1'b0);
    send('{0, 1}, 1'b1);

    // Clear colliding with a match, then the following overlap match.
    async_reset();
    send('{1, 0, 0}, 1'b1);
    step(1, 1, 1);
    send('{0, 0, 1}, 1'b1);

    // Five back-to-back overlapping matches on the 2-bit counter.
    async_reset();
    send('{1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1}, 1'b1);
    step(0, 0, 0);
    @(negedge clk);
    #1;
    check("dir_sat_cnt", int'(cnt_sat_o), 3);

    // Reset mid-pattern discards the partial match.
    async_reset();
    send('{1, 0, 0}, 1'b1);
    async_reset();
    send('{1, 0, 0, 1}, 1'b1);
    send('{1, 0, 0, 1}, 1'b1);

    // Randomized traffic with sparse clears and occasional resets.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) async_reset();
      step(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end

    step(0, 0, 0);
    step(0, 0, 0);
    @(negedge clk);
    #1;
    check("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
